// File: rtl/link_id_sequencer_pkg.sv
// Shared types and default constants for the link-ID sequencer slice.
package link_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FIRE,
        TAIL,
        GAP
    } link_seq_state_t;

    localparam int LINK_ID_RESERVED   = 0;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_GAP_CYCLES = 1100;
    localparam int DEFAULT_ID_W       = 6;

endpackage

// File: rtl/link_id_sequencer_if.sv
// Request handshake between the MAC side (master) and the link-ID sequencer (slave).
interface link_id_sequencer_if
    import link_seq_pkg::*;
#(
    parameter int ID_W = DEFAULT_ID_W
) ();

    logic            req_valid;
    logic [ID_W-1:0] req_id;
    logic            req_ready;

    modport master (output req_valid, output req_id, input req_ready);
    modport slave  (input req_valid, input req_id, output req_ready);

endinterface

// File: rtl/link_id_sequencer_fifo.sv
// Circular request queue with explicit occupancy count; DEPTH must be a power of two.
module link_id_fifo
    import link_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_ID_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    // NOTE: storage carries no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/link_id_sequencer.sv
// Queues link-ID requests and issues them to M_LEN as SETUP/FIRE/TAIL followed by a guard gap.
// Optional early gap termination via mlen_done when LINK_SEQ_DONE_EN is defined.
module link_id_sequencer
    import link_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int ID_W       = DEFAULT_ID_W
) (
    input  logic                          clk,
    input  logic                          n_rst,
    link_id_sequencer_if.slave            req_if,
`ifdef LINK_SEQ_DONE_EN
    input  logic                          mlen_done,
`endif
    output logic [ID_W-1:0]               link_id,
    output logic                          id_enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_zero_id
);

    localparam int              GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_RESERVED = ID_W'(LINK_ID_RESERVED);

    link_seq_state_t state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [ID_W-1:0]  link_id_q, link_id_d;
    logic             id_enable_q, id_enable_d;
    logic             busy_q, busy_d;
    logic             err_zero_q, err_zero_d;

    logic             req_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  fifo_head;
    logic             gap_done;

`ifdef LINK_SEQ_DONE_EN
    assign gap_done = mlen_done;
`else
    assign gap_done = 1'b0;
`endif

    // Ready holds low during reset so nothing is taken before the queue is usable.
    assign req_if.req_ready = n_rst & ~fifo_full;
    assign req_fire         = req_if.req_valid & req_if.req_ready;
    assign fifo_push        = req_fire && (req_if.req_id != ID_RESERVED);
    assign err_zero_d       = req_fire && (req_if.req_id == ID_RESERVED);

    link_id_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .push_i      (fifo_push),
        .push_data_i (req_if.req_id),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        gap_d    = gap_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    id_d     = fifo_head;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = FIRE;
            FIRE:  state_d = TAIL;
            TAIL: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_done || (gap_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        link_id_d   = (state_d inside {SETUP, FIRE, TAIL}) ? id_d : '0;
        id_enable_d = (state_d == FIRE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            gap_q       <= '0;
            link_id_q   <= '0;
            id_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            err_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            gap_q       <= gap_d;
            link_id_q   <= link_id_d;
            id_enable_q <= id_enable_d;
            busy_q      <= busy_d;
            err_zero_q  <= err_zero_d;
        end
    end

    assign link_id     = link_id_q;
    assign id_enable   = id_enable_q;
    assign busy        = busy_q;
    assign err_zero_id = err_zero_q;

endmodule

// File: tb/tb_link_id_sequencer.sv
// Scoreboard bench for link_id_sequencer: expected IDs queued at stimulus, compared as issues appear.
module tb_link_id_sequencer;

    localparam int TB_DEPTH = 4;
    localparam int TB_GAP   = 8;
    localparam int TB_ID_W  = 6;

    logic                        clk;
    logic                        n_rst;
    logic                        req_valid;
    logic [TB_ID_W-1:0]          req_id;
    logic                        req_ready;
    logic [TB_ID_W-1:0]          link_id;
    logic                        id_enable;
    logic                        busy;
    logic [$clog2(TB_DEPTH):0]   fifo_count;
    logic                        err_zero_id;
`ifdef LINK_SEQ_DONE_EN
    logic                        mlen_done;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [TB_ID_W-1:0] exp_q[$];
    logic [TB_ID_W-1:0] obs_id[$];
    int                 obs_cyc[$];

    link_id_sequencer_if #(.ID_W(TB_ID_W)) req_if ();

    assign req_if.req_valid = req_valid;
    assign req_if.req_id    = req_id;
    assign req_ready        = req_if.req_ready;

    link_id_sequencer #(
        .FIFO_DEPTH (TB_DEPTH),
        .GAP_CYCLES (TB_GAP),
        .ID_W       (TB_ID_W)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_if      (req_if),
`ifdef LINK_SEQ_DONE_EN
        .mlen_done   (mlen_done),
`endif
        .link_id     (link_id),
        .id_enable   (id_enable),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .err_zero_id (err_zero_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue monitor: records every strobe with the ID it carried.
    always @(negedge clk) begin
        if (n_rst && id_enable) begin
            obs_id.push_back(link_id);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_obs(input int need, input int budget, input string name);
        int n = 0;
        while (obs_id.size() < need && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (obs_id.size() < need) begin
            errors++;
            $display("FAIL %s_timeout: observed %0d issues, required %0d", name, obs_id.size(), need);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_count != 0) && n < TB_GAP + 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy || fifo_count != 0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b fifo_count=%0d, required 0/0", name, busy, fifo_count);
        end
    endtask

    task automatic test_reset();
        n_rst     = 1'b0;
        req_valid = 1'b1;
        req_id    = 6'h11;
`ifdef LINK_SEQ_DONE_EN
        mlen_done = 1'b0;
`endif
        #7;
        checks++;
        if ({link_id, id_enable, busy, fifo_count, err_zero_id, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: link_id=%0h id_enable=%0b busy=%0b fifo_count=%0d err=%0b ready=%0b, required all 0",
                     link_id, id_enable, busy, fifo_count, err_zero_id, req_ready);
        end
        n_rst     = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%0b, required 1", req_ready);
        end
        tick();
        checks++;
        if (fifo_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: fifo_count=%0d busy=%0b, required 0/0", fifo_count, busy);
        end
    endtask

    task automatic test_single();
        logic [TB_ID_W-1:0] exp_link;
        logic               exp_en;
        logic               exp_busy;
        wait_idle("single");
        req_valid = 1'b1;
        req_id    = 6'h04;
        exp_q.push_back(6'h04);
        for (int k = 1; k <= TB_GAP + 6; k++) begin
            tick();
            req_valid = 1'b0;
            exp_link = (k >= 2 && k <= 4) ? 6'h04 : 6'h00;
            exp_en   = (k == 3);
            exp_busy = (k >= 2 && k <= TB_GAP + 4);
            checks++;
            if (link_id !== exp_link) begin
                errors++;
                $display("FAIL single_link_id@+%0d: got %0h, required %0h", k, link_id, exp_link);
            end
            checks++;
            if (id_enable !== exp_en) begin
                errors++;
                $display("FAIL single_id_enable@+%0d: got %0b, required %0b", k, id_enable, exp_en);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL single_busy@+%0d: got %0b, required %0b", k, busy, exp_busy);
            end
            if (k == 1) begin
                checks++;
                if (err_zero_id !== 1'b0 || fifo_count !== 1) begin
                    errors++;
                    $display("FAIL single_enqueue: err=%0b fifo_count=%0d, required 0/1", err_zero_id, fifo_count);
                end
            end
        end
        wait_obs(1, 10, "single");
        while (exp_q.size() > 0) begin
            logic [TB_ID_W-1:0] e = exp_q.pop_front();
            checks++;
            if (obs_id.size() == 0) begin
                errors++;
                $display("FAIL single_id: no issue seen, required %0h", e);
            end else begin
                logic [TB_ID_W-1:0] o = obs_id.pop_front();
                void'(obs_cyc.pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_id: got %0h, required %0h", o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        wait_idle("b2b");
        req_valid = 1'b1;
        req_id    = 6'h04;
        exp_q.push_back(6'h04);
        tick();
        req_id    = 6'h05;
        exp_q.push_back(6'h05);
        tick();
        req_valid = 1'b0;
        wait_obs(2, 2 * (TB_GAP + 4) + 20, "b2b");
        if (obs_cyc.size() >= 2) begin
            c0 = obs_cyc[0];
            c1 = obs_cyc[1];
            checks++;
            if (c1 - c0 !== TB_GAP + 4) begin
                errors++;
                $display("FAIL b2b_period: got %0d cycles, required %0d", c1 - c0, TB_GAP + 4);
            end
        end
        while (exp_q.size() > 0) begin
            logic [TB_ID_W-1:0] e = exp_q.pop_front();
            checks++;
            if (obs_id.size() == 0) begin
                errors++;
                $display("FAIL b2b_id: no issue seen, required %0h", e);
            end else begin
                logic [TB_ID_W-1:0] o = obs_id.pop_front();
                void'(obs_cyc.pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_id: got %0h, required %0h", o, e);
                end
            end
        end
    endtask

    task automatic test_full_wrap();
        logic saw_full = 1'b0;
        wait_idle("full");
        for (int id = 1; id <= 6; id++) begin
            int n = 0;
            req_valid = 1'b1;
            req_id    = TB_ID_W'(id);
            while (!req_ready && n < 4 * (TB_GAP + 4)) begin
                saw_full = 1'b1;
                checks++;
                if (fifo_count !== TB_DEPTH) begin
                    errors++;
                    $display("FAIL full_ready_count: req_ready=0 with fifo_count=%0d, required %0d", fifo_count, TB_DEPTH);
                end
                tick();
                n++;
            end
            checks++;
            if (!req_ready) begin
                errors++;
                $display("FAIL full_stall: id %0d never accepted, req_ready=%0b required 1", id, req_ready);
            end else begin
                exp_q.push_back(TB_ID_W'(id));
            end
            tick();
            checks++;
            if (fifo_count > TB_DEPTH) begin
                errors++;
                $display("FAIL full_count_max: fifo_count=%0d, required <= %0d", fifo_count, TB_DEPTH);
            end
        end
        req_valid = 1'b0;
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_drop: saw req_ready low=%0b, required 1", saw_full);
        end
        wait_obs(6, 6 * (TB_GAP + 4) + 40, "full");
        while (exp_q.size() > 0) begin
            logic [TB_ID_W-1:0] e = exp_q.pop_front();
            checks++;
            if (obs_id.size() == 0) begin
                errors++;
                $display("FAIL full_order: no issue seen, required %0h", e);
            end else begin
                logic [TB_ID_W-1:0] o = obs_id.pop_front();
                void'(obs_cyc.pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL full_order: got %0h, required %0h", o, e);
                end
            end
        end
    endtask

    task automatic test_zero_id();
        wait_idle("zero");
        req_valid = 1'b1;
        req_id    = 6'h00;
        tick();
        req_valid = 1'b0;
        checks++;
        if (err_zero_id !== 1'b1 || fifo_count !== '0) begin
            errors++;
            $display("FAIL zero_pulse: err=%0b fifo_count=%0d, required 1/0", err_zero_id, fifo_count);
        end
        tick();
        checks++;
        if (err_zero_id !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse_width: err=%0b, required 0", err_zero_id);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (id_enable !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_no_issue: id_enable=%0b busy=%0b, required 0/0", id_enable, busy);
            end
        end
        checks++;
        if (obs_id.size() != 0) begin
            errors++;
            $display("FAIL zero_no_issue_seen: %0d issues, required 0", obs_id.size());
        end
    endtask

`ifdef LINK_SEQ_DONE_EN
    task automatic test_mlen_done();
        int c0;
        int c1;
        wait_idle("done");
        req_valid = 1'b1;
        req_id    = 6'h09;
        exp_q.push_back(6'h09);
        tick();
        req_id    = 6'h0a;
        exp_q.push_back(6'h0a);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || link_id !== '0) begin
            errors++;
            $display("FAIL done_in_gap: busy=%0b link_id=%0h, required 1/0", busy, link_id);
        end
        mlen_done = 1'b1;
        tick();
        mlen_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: busy=%0b, required 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || link_id !== 6'h0a || id_enable !== 1'b0) begin
            errors++;
            $display("FAIL done_setup: busy=%0b link_id=%0h en=%0b, required 1/0a/0", busy, link_id, id_enable);
        end
        wait_obs(2, 20, "done");
        if (obs_cyc.size() >= 2) begin
            c0 = obs_cyc[0];
            c1 = obs_cyc[1];
            checks++;
            if (c1 - c0 !== 7) begin
                errors++;
                $display("FAIL done_period: got %0d cycles, required 7", c1 - c0);
            end
        end
        while (exp_q.size() > 0) begin
            logic [TB_ID_W-1:0] e = exp_q.pop_front();
            checks++;
            if (obs_id.size() == 0) begin
                errors++;
                $display("FAIL done_id: no issue seen, required %0h", e);
            end else begin
                logic [TB_ID_W-1:0] o = obs_id.pop_front();
                void'(obs_cyc.pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL done_id: got %0h, required %0h", o, e);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_fire();
        wait_idle("rstfire");
        req_valid = 1'b1;
        req_id    = 6'h07;
        exp_q.push_back(6'h07);
        tick();
        req_id    = 6'h08;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (id_enable !== 1'b1 || link_id !== 6'h07) begin
            errors++;
            $display("FAIL rstfire_fire: id_enable=%0b link_id=%0h, required 1/07", id_enable, link_id);
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (id_enable !== 1'b0 || link_id !== '0 || fifo_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstfire_async: en=%0b link_id=%0h fifo_count=%0d busy=%0b, required all 0",
                     id_enable, link_id, fifo_count, busy);
        end
        repeat (3) tick();
        n_rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (id_enable !== 1'b0 || fifo_count !== '0) begin
                errors++;
                $display("FAIL rstfire_no_issue: en=%0b fifo_count=%0d, required 0/0", id_enable, fifo_count);
            end
        end
        while (exp_q.size() > 0) begin
            logic [TB_ID_W-1:0] e = exp_q.pop_front();
            checks++;
            if (obs_id.size() == 0) begin
                errors++;
                $display("FAIL rstfire_id: no issue seen, required %0h", e);
            end else begin
                logic [TB_ID_W-1:0] o = obs_id.pop_front();
                void'(obs_cyc.pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL rstfire_id: got %0h, required %0h", o, e);
                end
            end
        end
        checks++;
        if (obs_id.size() != 0) begin
            errors++;
            $display("FAIL rstfire_extra: %0d issues after reset, required 0", obs_id.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_wrap();
        test_zero_id();
`ifdef LINK_SEQ_DONE_EN
        test_mlen_done();
`endif
        test_reset_mid_fire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
